// File: rtl/debounce_64.sv
// Debouncer for one asynchronous, bouncy input: a flop synchroniser followed by
// a stability filter that commits a new level only after it has held for
// STABLE_CYCLES consecutive clocks, plus one-cycle press/release strobes.
module debounce_64 #(
   parameter int unsigned STABLE_CYCLES = 64,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter logic        RESET_LEVEL   = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic noisy_in,
   output logic clean_out,
   output logic rise_pulse,
   output logic fall_pulse
);

   localparam int unsigned CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   clean_q, clean_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   sync_in;

   assign sync_in = sync_q[SYNC_STAGES-1];

   // Next-state: shift the synchroniser, count disagreement, commit at the threshold.
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], noisy_in};
      cnt_d   = cnt_q;
      clean_d = clean_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync_in != clean_q) begin
         if (cnt_q == CNT_MAX) begin
            clean_d = sync_in;
            cnt_d   = '0;
            rise_d  = sync_in;
            fall_d  = ~sync_in;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         // Any sample agreeing with the committed level restarts the count.
         cnt_d = '0;
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
         cnt_q   <= '0;
         clean_q <= RESET_LEVEL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign clean_out  = clean_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;

endmodule

// File: tb/tb_debounce_64.sv
// Randomised plus directed bench for debounce_64 with a scoreboard: the driver
// pushes the expected outputs per clock, a monitor pops and compares them.
module tb_debounce_64;

   localparam int unsigned STABLE = 64;
   localparam int unsigned SYNC   = 2;
   localparam logic        RLVL   = 1'b0;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic noisy_in = 1'b0;
   logic clean_out, rise_pulse, fall_pulse;

   debounce_64 #(.STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC), .RESET_LEVEL(RLVL)) dut (
      .clk(clk), .reset(reset), .noisy_in(noisy_in),
      .clean_out(clean_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
   );

   always #10 clk = ~clk;

   typedef struct packed {
      logic clean;
      logic rise;
      logic fall;
   } exp_t;

   exp_t expq[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model: synchroniser as a queue of samples, filter as a window rule
   // over the history of filtered samples since the last commit or reset.
   logic   pipe[$];
   logic   hist[int];
   int     edge_m   = 0;
   int     last_evt = 0;
   logic   clean_m  = RLVL;

   function automatic exp_t model_step(input logic r, input logic n);
      exp_t e;
      logic fin;
      bit   commit;
      edge_m++;
      e = '0;
      if (r) begin
         pipe.delete();
         for (int i = 0; i < int'(SYNC); i++) pipe.push_back(RLVL);
         clean_m  = RLVL;
         last_evt = edge_m;
      end else begin
         fin = pipe.pop_front();
         pipe.push_back(n);
         hist[edge_m] = fin;
         commit = (edge_m - last_evt) >= int'(STABLE);
         if (commit)
            for (int k = 0; k < int'(STABLE); k++)
               if (hist[edge_m - k] == clean_m) commit = 0;
         if (commit) begin
            clean_m  = fin;
            e.rise   = fin;
            e.fall   = ~fin;
            last_evt = edge_m;
         end
      end
      e.clean = clean_m;
      return e;
   endfunction

   // Apply one cycle of stimulus on the falling edge and record its expectation.
   task automatic drive(input logic r, input logic n);
      @(negedge clk);
      reset    = r;
      noisy_in = n;
      expq.push_back(model_step(r, n));
   endtask

   task automatic hold(input logic n, input int cycles);
      for (int i = 0; i < cycles; i++) drive(1'b0, n);
   endtask

   // Hold a level and measure edges from the first sampling edge to the commit.
   task automatic hold_lat(input string name, input logic n, input int cycles);
      int  t0;
      int  lat;
      bit  seen;
      t0   = edge_m + 1;
      lat  = -1;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         drive(1'b0, n);
         if (!seen && clean_out === n) begin
            seen = 1;
            lat  = edge_m - t0;
         end
      end
      n_cmp++;
      if (lat != int'(SYNC + STABLE)) begin
         n_err++;
         $display("FAIL %s: latency got %0d edges, expected %0d", name, lat, SYNC + STABLE);
      end
   endtask

   // Monitor: compare every clock against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            n_cmp++;
            if ({clean_out, rise_pulse, fall_pulse} !== e) begin
               n_err++;
               $display("FAIL outputs @%0t: got clean/rise/fall=%b%b%b expected %b%b%b",
                        $time, clean_out, rise_pulse, fall_pulse, e.clean, e.rise, e.fall);
            end
            n_cmp++;
            if (rise_pulse === 1'b1 && fall_pulse === 1'b1) begin
               n_err++;
               $display("FAIL strobes @%0t: rise and fall both high", $time);
            end
         end
      end
   end

   initial begin
      int len;
      logic lvl;
      // Reset held with the input high.
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
      hold(1'b0, 5);
      // Press bounce never commits.
      hold(1'b1, 10); hold(1'b0, 3); hold(1'b1, 7); hold(1'b0, 80);
      // Stable press.
      hold_lat("press_latency", 1'b1, 250);
      // Release bounce then a stable release.
      hold(1'b0, 5); hold(1'b1, 4); hold(1'b0, 20); hold(1'b1, 2);
      hold_lat("release_latency", 1'b0, 100);
      // Threshold: 63 synced cycles is not enough, 64 commits.
      hold(1'b1, 63); hold(1'b0, 80);
      hold(1'b1, 64); hold(1'b0, 100);
      // Reset mid-count discards progress; a full new hold is needed.
      hold(1'b1, 42);
      drive(1'b1, 1'b1);
      hold_lat("reset_midcount_latency", 1'b1, 100);
      hold(1'b0, 100);
      // Randomised runs with occasional resets.
      for (int i = 0; i < 60; i++) begin
         lvl = 1'($urandom_range(1, 0));
         len = $urandom_range(120, 1);
         if ($urandom_range(19, 0) == 0) drive(1'b1, lvl);
         hold(lvl, len);
      end
      // Fast toggling keeps the committed level.
      for (int i = 0; i < 200; i++) drive(1'b0, 1'(i % 2));
      repeat (3) @(posedge clk);
      #2;
      n_cmp++;
      if (expq.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left, expected 0", expq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
